inst_mem_ctrl: RTL and testbench

Parametrised instruction-memory controller: the successor to the fixed 1024-word combinational instruction ROM. It serves fetch requests from the IF stage through a valid/ready handshake with a configurable read latency (wait states), and cancels in-flight fetches on pipeline flush. A boot-load write port lets a host program the array before run. Misaligned and out-of-range fetches are reported as faults.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_array.sv | 38 +++
 rtl/inst_mem_ctrl.sv | 124 ++++++++++++
 tb/tb_inst_mem_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction-memory
//               controller: FSM state encoding, default fault word and the
//               fetch-port disable/enable levels.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Controller states; BUSY covers the whole wait-state window of a fetch.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } imem_state_e;

  // Word handed back for misaligned / out-of-range fetches.
  localparam logic [31:0] c_nop_word    = 32'h0000_0000;

  // Fetch-port enable levels: disabled while in reset, enabled once running.
  localparam logic        c_rom_disable = 1'b0;
  localparam logic        c_rom_enable  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module      : imem_array
// Description : DEPTH x DATA_W instruction storage. Synchronous write port,
//               asynchronous read port, no reset (contents survive rst_n).
// Ports       : clk      - write clock
//               we_i     - write strobe
//               waddr_i  - word index to write
//               wdata_i  - write data
//               raddr_i  - word index to read
//               rdata_o  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/inst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_ctrl
// Description : Instruction-memory controller. Serves IF-stage fetches over a
//               valid/ready handshake with LATENCY wait states, cancels the
//               in-flight fetch on flush or !ce, reports misaligned and
//               out-of-range fetches as faults, and accepts boot-load writes
//               while idle.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               ce, flush           - fetch enable, fetch cancel
//               req_valid/req_addr  - fetch request (byte address)
//               req_ready           - request accepted when valid && ready
//               rsp_valid           - one-cycle response strobe
//               rsp_data/rsp_fault  - fetched word / fault flag
//               load_en/addr/data   - boot-load write port
//               busy                - fetch in flight
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       LATENCY  = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(c_nop_word)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
);

  localparam int unsigned      IDX_W      = $clog2(DEPTH);
  localparam int unsigned      CNT_W      = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);

  // Misaligned or beyond the last word. The range test is done 64 bits wide
  // so it is correct for any ADDR_W / DEPTH combination.
  function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (64'(a) >= (64'(DEPTH) * 64'd4));
  endfunction

  imem_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              run_q;

  logic              w_cancel;
  logic              w_rsp_due;
  logic              w_ready;
  logic              w_accept;
  logic              w_load_we;
  logic              w_fetch_fault;
  logic [DATA_W-1:0] w_rdata;

  assign w_cancel  = !ce || flush;
  assign w_rsp_due = (state_q == BUSY) && (cnt_q == '0);
  // run_q keeps the port closed while reset is held and for the first edge
  // after release.
  assign w_ready   = (run_q == c_rom_enable) && !w_cancel && !load_en &&
                     ((state_q == IDLE) || w_rsp_due);
  assign w_accept  = req_valid && w_ready;
  assign w_load_we = load_en && (state_q == IDLE) && !addr_fault(load_addr);
  assign w_fetch_fault = addr_fault(addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      run_q   <= c_rom_disable;
    end else begin
      run_q <= c_rom_enable;
      if (w_cancel) begin
        // Cancellation beats both a due response and a new request.
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (w_accept) begin
        state_q <= BUSY;
        cnt_q   <= c_cnt_load;
        addr_q  <= req_addr;
      end else if (state_q == BUSY) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (w_load_we),
    .waddr_i (load_addr[IDX_W+1:2]),
    .wdata_i (load_data),
    .raddr_i (addr_q[IDX_W+1:2]),
    .rdata_o (w_rdata)
  );

  assign req_ready = w_ready;
  assign rsp_valid = w_rsp_due && !w_cancel;
  assign rsp_fault = rsp_valid && w_fetch_fault;
  assign rsp_data  = !rsp_valid    ? '0 :
                     w_fetch_fault ? NOP_WORD : w_rdata;
  assign busy      = (state_q == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_mem_ctrl
// Description : Self-checking bench for inst_mem_ctrl. Four instances with
//               LATENCY 1..4 share one stimulus stream. Directed vector table,
//               a reset-during-fetch sequence, then randomized traffic against
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        rdy  [4];
  logic        val  [4];
  logic [31:0] rdat [4];
  logic        flt  [4];
  logic        bsy  [4];

  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    inst_mem_ctrl #(.LATENCY(g + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce        (ce),
      .flush     (flush),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (rdy[g]),
      .rsp_valid (val[g]),
      .rsp_data  (rdat[g]),
      .rsp_fault (flt[g]),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .busy      (bsy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic i_ce, input logic i_fl, input logic i_rv,
                       input logic [31:0] i_ra, input logic i_le,
                       input logic [31:0] i_la, input logic [31:0] i_ld);
    ce = i_ce; flush = i_fl; req_valid = i_rv; req_addr = i_ra;
    load_en = i_le; load_addr = i_la; load_data = i_ld;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  task automatic chk_all(input string tag, input int k, input logic e_rdy,
                         input logic e_val, input logic [31:0] e_data,
                         input logic e_flt, input logic e_busy);
    chk($sformatf("%s L%0d rdy",  tag, k + 1), rdy[k],  e_rdy);
    chk($sformatf("%s L%0d val",  tag, k + 1), val[k],  e_val);
    chk($sformatf("%s L%0d data", tag, k + 1), rdat[k], e_data);
    chk($sformatf("%s L%0d flt",  tag, k + 1), flt[k],  e_flt);
    chk($sformatf("%s L%0d busy", tag, k + 1), bsy[k],  e_busy);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          d;      // instance checked: LATENCY = d+1
    logic        fl;
    logic        rv;
    logic [31:0] ra;
    logic        le;
    logic [31:0] la;
    logic [31:0] ld;
    logic        e_rdy;
    logic        e_val;
    logic [31:0] e_data;
    logic        e_flt;
    logic        e_busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int d, logic fl, logic rv, logic [31:0] ra,
                              logic le, logic [31:0] la, logic [31:0] ld,
                              logic e_rdy, logic e_val, logic [31:0] e_data,
                              logic e_flt, logic e_busy);
    vec_t v;
    v.d = d; v.fl = fl; v.rv = rv; v.ra = ra; v.le = le; v.la = la; v.ld = ld;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_data = e_data;
    v.e_flt = e_flt; v.e_busy = e_busy;
    return v;
  endfunction

  // ---------------- reference model ----------------
  bit          m_pend [4];
  longint      m_due  [4];
  logic [31:0] m_addr [4];
  logic [31:0] m_mem  [4][1024];
  longint      cyc;

  function automatic bit is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd4096);
  endfunction

  task automatic model_cycle(input logic i_ce, input logic i_fl, input logic i_rv,
                             input logic [31:0] i_ra, input logic i_le,
                             input logic [31:0] i_la, input logic [31:0] i_ld);
    bit          due_now;
    bit          e_rdy;
    bit          e_val;
    bit          e_flt;
    logic [31:0] e_data;
    @(posedge clk); #1;
    drive(i_ce, i_fl, i_rv, i_ra, i_le, i_la, i_ld);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      due_now = m_pend[k] && (m_due[k] == cyc);
      e_rdy   = i_ce && !i_fl && !i_le && (!m_pend[k] || due_now);
      e_val   = due_now && i_ce && !i_fl;
      e_flt   = e_val && is_fault(m_addr[k]);
      e_data  = !e_val ? 32'h0 : (e_flt ? 32'h0 : m_mem[k][m_addr[k][11:2]]);
      chk_all($sformatf("rnd c%0d", cyc), k, e_rdy, e_val, e_data, e_flt, m_pend[k]);
      if (i_le && !m_pend[k] && !is_fault(i_la)) m_mem[k][i_la[11:2]] = i_ld;
      if (!i_ce || i_fl) m_pend[k] = 1'b0;
      else if (e_rdy && i_rv) begin
        m_pend[k] = 1'b1;
        m_due[k]  = cyc + k + 1;
        m_addr[k] = i_ra;
      end else if (due_now) m_pend[k] = 1'b0;
    end
    cyc++;
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    else if (r == 7) return {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
    else if (r == 8) return 32'h1000 + {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
    else             return $urandom;
  endfunction

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;

    // -------- reset values --------
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk_all("reset", k, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // -------- directed table --------
    // loads
    vt.push_back(mk(0,0,0,32'h0,   1,32'h0,32'h3401_0004, 0,0,32'h0,0,0));
    vt.push_back(mk(0,0,0,32'h0,   1,32'h4,32'h0001_1020, 0,0,32'h0,0,0));
    // LATENCY=1 back-to-back 0x0, 0x4
    vt.push_back(mk(0,0,1,32'h0,   0,0,0, 1,0,32'h0,0,0));
    vt.push_back(mk(0,0,1,32'h4,   0,0,0, 1,1,32'h3401_0004,0,1));
    vt.push_back(mk(0,0,0,32'h0,   0,0,0, 1,1,32'h0001_1020,0,1));
    vt.push_back(mk(0,0,0,32'h0,   0,0,0, 1,0,32'h0,0,0));
    vt.push_back(mk(0,0,0,32'h0,   0,0,0, 1,0,32'h0,0,0));
    // LATENCY=3 fetch 0x4, second request (0x0) held until accepted at T+3
    vt.push_back(mk(2,0,1,32'h4,   0,0,0, 1,0,32'h0,0,0));
    vt.push_back(mk(2,0,1,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(2,0,1,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(2,0,1,32'h0,   0,0,0, 1,1,32'h0001_1020,0,1));
    vt.push_back(mk(2,0,0,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(2,0,0,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(2,0,0,32'h0,   0,0,0, 1,1,32'h3401_0004,0,1));
    // faults on LATENCY=1
    vt.push_back(mk(0,0,1,32'h2,   0,0,0, 1,0,32'h0,0,0));
    vt.push_back(mk(0,0,1,32'h1000,0,0,0, 1,1,32'h0,1,1));
    vt.push_back(mk(0,0,0,32'h0,   0,0,0, 1,1,32'h0,1,1));
    vt.push_back(mk(0,0,0,32'h0,   0,0,0, 1,0,32'h0,0,0));
    vt.push_back(mk(0,0,0,32'h0,   0,0,0, 1,0,32'h0,0,0));
    // LATENCY=4 flush at T+2, new request at T+3
    vt.push_back(mk(3,0,1,32'h4,   0,0,0, 1,0,32'h0,0,0));
    vt.push_back(mk(3,0,0,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(3,1,0,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(3,0,1,32'h0,   0,0,0, 1,0,32'h0,0,0));
    vt.push_back(mk(3,0,0,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(3,0,0,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(3,0,0,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(3,0,0,32'h0,   0,0,0, 1,1,32'h3401_0004,0,1));
    // load and request in the same idle cycle: load wins
    vt.push_back(mk(0,0,1,32'h8,   1,32'h8,32'hDEAD_BEEF, 0,0,32'h0,0,0));
    vt.push_back(mk(0,0,1,32'h8,   0,0,0, 1,0,32'h0,0,0));
    vt.push_back(mk(0,0,0,32'h0,   0,0,0, 1,1,32'hDEAD_BEEF,0,1));
    // load while LATENCY=4 is busy is ignored there (LATENCY=1 is idle and takes it)
    vt.push_back(mk(3,0,0,32'h0,   1,32'h8,32'h0BAD_F00D, 0,0,32'h0,0,1));
    vt.push_back(mk(3,0,0,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(3,0,0,32'h0,   0,0,0, 1,1,32'hDEAD_BEEF,0,1));
    vt.push_back(mk(3,0,1,32'h8,   0,0,0, 1,0,32'h0,0,0));
    vt.push_back(mk(0,0,0,32'h0,   0,0,0, 1,1,32'h0BAD_F00D,0,1));
    vt.push_back(mk(3,0,0,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(3,0,0,32'h0,   0,0,0, 0,0,32'h0,0,1));
    vt.push_back(mk(3,0,0,32'h0,   0,0,0, 1,1,32'hDEAD_BEEF,0,1));

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      drive(1'b1, vt[i].fl, vt[i].rv, vt[i].ra, vt[i].le, vt[i].la, vt[i].ld);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), vt[i].d, vt[i].e_rdy, vt[i].e_val,
              vt[i].e_data, vt[i].e_flt, vt[i].e_busy);
    end

    // -------- reset during a LATENCY=2 fetch --------
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstfetch accept rdy", rdy[1], 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) chk_all("rstfetch mid", k, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rstfetch T+2 val", val[1], 1'b0);
    chk("rstfetch T+2 busy", bsy[1], 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("postrst rdy", rdy[1], 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("postrst T+1 val", val[1], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst T+2 val", val[1], 1'b1);
    chk("postrst T+2 data", rdat[1], 32'h0001_1020);

    // -------- randomized traffic against the model --------
    idle_cycles(6);
    cyc = 0;
    for (int k = 0; k < 4; k++) m_pend[k] = 1'b0;
    for (int w = 0; w < 1024; w++)
      model_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'(w * 4), $urandom);
    for (int n = 0; n < 2500; n++)
      model_cycle($urandom_range(0, 19) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7, rnd_addr(),
                  $urandom_range(0, 19) == 0, rnd_addr(), $urandom);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
